mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Pipelined, multi-cycle data/instruction memory that services the requests the pipelined CPU issues over its enable/wr/addr/data_in memory interface.
- Accepts one request per cycle. Read data returns in order after a fixed LATENCY with a one-cycle valid strobe.
- Stands in for the single-cycle memory once the cache fill logic comes up, so the core and cache can be verified against realistic multi-cycle timing.

Parameters:
- ADDR_WIDTH, 16, byte-address width; array holds 2^(ADDR_WIDTH-1) 16-bit words.
- LATENCY, 4, cycles from request acceptance to read data valid; legal range 1..8.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  request present this cycle.
- wr  input  1  1 = write, 0 = read; qualified by enable.
- addr  input  ADDR_WIDTH  byte address; addr[0] ignored (word aligned).
- data_in  input  16  write data.
- data_out  output  16  read data; valid only while data_valid = 1, 16'h0000 otherwise.
- data_valid  output  1  one-cycle strobe per completed read.
- resp_addr  output  ADDR_WIDTH  word-aligned address of the read on data_out (bit 0 forced 0); 0 when not valid.
- busy  output  1  1 while any accepted read has not yet returned.

Behaviour:
- Acceptance: request accepted at every rising edge where enable = 1 and rst = 0. No backpressure: one request per cycle, always accepted.
- Write: array[addr[ADDR_WIDTH-1:1]] <= data_in at the accepting edge. No response, no data_valid. Does not affect busy.
- Read: array word is sampled at the accepting edge, so it includes all writes accepted at earlier edges. The sampled value and the address then travel a delay line.
- Read timing: accepted at edge E0 -> data_valid = 1, data_out and resp_addr driven for exactly the cycle following edge E0+(LATENCY-1).
  - LATENCY = 1 behaves as a synchronous single-cycle read.
- Ordering: responses strictly in request order; back-to-back reads produce back-to-back data_valid cycles.
- Read-after-write: a write at edge k followed by a read of the same word at edge k+1 returns the new data. Write and read cannot share an edge (single port).
- busy = OR of delay-line valid bits plus the output-stage valid; it is 0 in the cycle after the last data_valid.
- In-flight counter: 4-bit, increments on read accept, decrements on data_valid, both in the same cycle leaves it unchanged. Counter is never observable above LATENCY. busy must equal (count != 0); the bench checks this.
- Reset (async, rst = 1): all delay-line valid bits cleared; data_valid = 0, data_out = 0, resp_addr = 0, busy = 0, counter = 0 immediately (no clock needed).
  - Array contents are NOT reset; reads of never-written words return X in simulation.
- Reset mid-operation: all in-flight reads are discarded and produce no strobe after rst deasserts. A write presented during reset is not committed.
- enable = 0: no state change other than delay-line advance.
- Address wrap: none; addresses beyond the array do not exist because array depth = 2^(ADDR_WIDTH-1).

Decomposition:
- Shared package mem_pkg: WORD_WIDTH = 16; MAX_LATENCY = 8; default LATENCY = 4.
- Sub-module mem_delay_line: parameterised depth shift register of {valid, addr, data}. Async active-high reset clears valid bits only. Depth LATENCY-1; LATENCY = 1 means pass-through.
- Top level holds the array, the acceptance logic, the counter and the output stage.

Test Plan:
- Write 16'hBEEF to 0x0010, next cycle read 0x0010 (LATENCY = 4) -> data_valid high exactly 4 cycles after the read edge, data_out = 16'hBEEF, resp_addr = 0x0010.
- Write 0x1111/0x2222/0x3333 to 0x0000/0x0002/0x0004, then 3 consecutive reads -> 3 consecutive data_valid cycles, data in order 0x1111, 0x2222, 0x3333; busy falls the cycle after the third.
- Write 16'hA5A5 to 0x0020, read 0x0021 -> 16'hA5A5, resp_addr = 0x0020.
- Issue 2 reads, assert rst 2 cycles later for 1 cycle -> data_valid/busy/data_out drop to 0 asynchronously; no strobe ever appears for those reads.
- LATENCY = 1 build: write 0x0042 to 0x0100, then read -> data_valid in the cycle right after the read edge, data_out = 0x0042.
- Interleave write 0x0008 = 0x1234, read 0x0008, write 0x0008 = 0x5678, read 0x0008 on consecutive edges -> responses 0x1234 then 0x5678.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared constants and types for the multi-cycle memory responder.
package mem_pkg;

  // Width of one memory word and of the read/write data buses.
  localparam int WORD_WIDTH = 16;

  // Largest supported request-to-data latency, and the default build value.
  localparam int MAX_LATENCY     = 8;
  localparam int DEFAULT_LATENCY = 4;

  // The in-flight read counter must be able to hold MAX_LATENCY.
  localparam int COUNT_WIDTH = 4;

  typedef logic [WORD_WIDTH-1:0]  word_t;
  typedef logic [COUNT_WIDTH-1:0] count_t;

  // True when a latency value lies inside the supported range.
  function automatic bit latency_ok(input int lat);
    return (lat >= 1) && (lat <= MAX_LATENCY);
  endfunction

endpackage

// File: rtl/mem_delay_line.sv
// Fixed-depth shift register carrying {valid, addr, data} for read responses.
// Reset clears only the valid bits; address and data are plain pipeline flops.
// DEPTH = 0 degenerates to a combinational pass-through.
module mem_delay_line
  import mem_pkg::*;
#(
  parameter int DEPTH      = DEFAULT_LATENCY - 1,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  any_valid
);

  if (DEPTH == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    assign out_valid = in_valid;
    assign out_addr  = in_addr;
    assign out_data  = in_data;
    assign any_valid = 1'b0;
  end else begin : g_shift
    logic [DEPTH-1:0]      valid_q;
    logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];

    // Advance the valid bits every cycle; reset discards everything in flight.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= '0;
      end else begin
        valid_q[0] <= in_valid;
        for (int i = 1; i < DEPTH; i++) begin
          valid_q[i] <= valid_q[i-1];
        end
      end
    end

    // Advance the payload alongside the valid bits; no reset needed.
    always_ff @(posedge clk) begin
      addr_q[0] <= in_addr;
      data_q[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
        addr_q[i] <= addr_q[i-1];
        data_q[i] <= data_q[i-1];
      end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_addr  = addr_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];
    assign any_valid = |valid_q;
  end

endmodule

// File: rtl/mem_responder.sv
// Pipelined multi-cycle memory: one request per cycle, in-order read data
// after LATENCY cycles with a one-cycle valid strobe.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int LATENCY    = DEFAULT_LATENCY
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  wr,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WORD_WIDTH-1:0] data_in,
  output logic [WORD_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic [ADDR_WIDTH-1:0] resp_addr,
  output logic                  busy
);

  localparam int WORDS = 1 << (ADDR_WIDTH - 1);
  localparam int DEPTH = (latency_ok(LATENCY) ? LATENCY : DEFAULT_LATENCY) - 1;

  word_t                   mem [WORDS];
  logic [ADDR_WIDTH-2:0]   word_idx;
  logic [ADDR_WIDTH-1:0]   aligned_addr;
  logic                    unused_addr_lsb;
  logic                    wr_accept;
  logic                    rd_accept;
  word_t                   read_word;

  logic                    dl_valid;
  logic [ADDR_WIDTH-1:0]   dl_addr;
  word_t                   dl_data;
  logic                    dl_any;

  logic                    out_valid;
  logic [ADDR_WIDTH-1:0]   out_addr;
  word_t                   out_data;
  count_t                  in_flight;

  assign word_idx        = addr[ADDR_WIDTH-1:1];
  assign aligned_addr    = {addr[ADDR_WIDTH-1:1], 1'b0};
  assign unused_addr_lsb = addr[0];

  // Nothing is accepted while reset is held, so a write during reset is dropped.
  assign wr_accept = enable & wr & ~rst;
  assign rd_accept = enable & ~wr & ~rst;

  // Single-port array read; sees every write committed at earlier edges.
  assign read_word = mem[word_idx];

  // Commit writes at the accepting edge; array contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[word_idx] <= data_in;
    end
  end

  mem_delay_line #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (WORD_WIDTH)
  ) u_delay (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_accept),
    .in_addr   (aligned_addr),
    .in_data   (read_word),
    .out_valid (dl_valid),
    .out_addr  (dl_addr),
    .out_data  (dl_data),
    .any_valid (dl_any)
  );

  // Output stage: drive data and address only during the strobe cycle, zero otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
    end else begin
      out_valid <= dl_valid;
      out_addr  <= dl_valid ? dl_addr : '0;
      out_data  <= dl_valid ? dl_data : '0;
    end
  end

  // Count reads accepted but not yet returned; simultaneous accept and return cancel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_flight <= '0;
    end else begin
      case ({rd_accept, out_valid})
        2'b10:   in_flight <= in_flight + count_t'(1);
        2'b01:   in_flight <= in_flight - count_t'(1);
        default: in_flight <= in_flight;
      endcase
    end
  end

  assign data_valid = out_valid;
  assign data_out   = out_data;
  assign resp_addr  = out_addr;
  assign busy       = dl_any | out_valid;

  // The counter and the pipeline valid bits describe the same in-flight set.
  busy_matches_count : assert property (@(posedge clk) disable iff (rst)
    busy == (in_flight != '0));

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: table-driven request stream with a
// response scoreboard, plus hand-written reset and single-cycle-latency sequences.
module tb_mem_responder;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0, wr = 1'b0;
  logic [15:0] addr = '0, data_in = '0;
  logic [15:0] data_out, resp_addr;
  logic        data_valid, busy;

  logic        en1 = 1'b0, wr1 = 1'b0;
  logic [15:0] addr1 = '0, din1 = '0;
  logic [15:0] dout1, raddr1;
  logic        valid1, busy1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_on = 1'b0;

  typedef struct {
    logic        en;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] din;
    logic [15:0] exp_data;
    logic [15:0] exp_addr;
  } vec_t;

  typedef struct {
    logic [15:0] data;
    logic [15:0] addr;
    int          acc_cyc;
    int          exp_cyc;
  } resp_t;

  resp_t sb[$];
  vec_t  vecs[18];

  mem_responder #(.ADDR_WIDTH(16), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .wr         (wr),
    .addr       (addr),
    .data_in    (data_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .resp_addr  (resp_addr),
    .busy       (busy)
  );

  mem_responder #(.ADDR_WIDTH(16), .LATENCY(1)) dut1 (
    .clk        (clk),
    .rst        (rst),
    .enable     (en1),
    .wr         (wr1),
    .addr       (addr1),
    .data_in    (din1),
    .data_out   (dout1),
    .data_valid (valid1),
    .resp_addr  (raddr1),
    .busy       (busy1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Drive one request on the LATENCY=4 instance; reads push their expected response.
  task automatic applyStimulus(input logic en_v, input logic wr_v, input logic [15:0] a,
                               input logic [15:0] d, input logic [15:0] ed,
                               input logic [15:0] ea);
    @(negedge clk);
    enable  = en_v;
    wr      = wr_v;
    addr    = a;
    data_in = d;
    if (en_v && !wr_v)
      sb.push_back('{data: ed, addr: ea, acc_cyc: cyc + 1, exp_cyc: cyc + LAT});
  endtask

  // Scoreboard monitor: exact-cycle response check, idle-zero check, busy check.
  always @(negedge clk) begin
    if (mon_on) begin
      logic  busy_exp;
      resp_t r;
      busy_exp = (sb.size() > 0) && (sb[0].acc_cyc <= cyc);
      checkOutput("busy", {31'd0, busy}, {31'd0, busy_exp});
      if (sb.size() > 0 && sb[0].exp_cyc == cyc) begin
        r = sb.pop_front();
        checkOutput("resp_valid", {31'd0, data_valid}, 32'd1);
        checkOutput("resp_data", {16'd0, data_out}, {16'd0, r.data});
        checkOutput("resp_addr", {16'd0, resp_addr}, {16'd0, r.addr});
      end else begin
        checkOutput("idle_valid", {31'd0, data_valid}, 32'd0);
        checkOutput("idle_data", {16'd0, data_out}, 32'd0);
        checkOutput("idle_addr", {16'd0, resp_addr}, 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: got no finish, expected finish before 100000");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 16'h0010, 16'hBEEF, 16'h0000, 16'h0000};
    vecs[1]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 16'h0010};
    vecs[2]  = '{1'b1, 1'b1, 16'h0000, 16'h1111, 16'h0000, 16'h0000};
    vecs[3]  = '{1'b1, 1'b1, 16'h0002, 16'h2222, 16'h0000, 16'h0000};
    vecs[4]  = '{1'b1, 1'b1, 16'h0004, 16'h3333, 16'h0000, 16'h0000};
    vecs[5]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'h1111, 16'h0000};
    vecs[6]  = '{1'b1, 1'b0, 16'h0002, 16'h0000, 16'h2222, 16'h0002};
    vecs[7]  = '{1'b1, 1'b0, 16'h0004, 16'h0000, 16'h3333, 16'h0004};
    vecs[8]  = '{1'b1, 1'b1, 16'h0020, 16'hA5A5, 16'h0000, 16'h0000};
    vecs[9]  = '{1'b1, 1'b0, 16'h0021, 16'h0000, 16'hA5A5, 16'h0020};
    vecs[10] = '{1'b1, 1'b1, 16'h0008, 16'h1234, 16'h0000, 16'h0000};
    vecs[11] = '{1'b1, 1'b0, 16'h0008, 16'h0000, 16'h1234, 16'h0008};
    vecs[12] = '{1'b1, 1'b1, 16'h0008, 16'h5678, 16'h0000, 16'h0000};
    vecs[13] = '{1'b1, 1'b0, 16'h0008, 16'h0000, 16'h5678, 16'h0008};
    vecs[14] = '{1'b0, 1'b1, 16'h0010, 16'hFFFF, 16'h0000, 16'h0000};
    vecs[15] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 16'h0010};
    vecs[16] = '{1'b1, 1'b1, 16'hFFFE, 16'h7E57, 16'h0000, 16'h0000};
    vecs[17] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'h7E57, 16'hFFFE};

    // Asynchronous reset before any clock edge
    #1 rst = 1'b1;
    #2;
    checkOutput("rst_valid", {31'd0, data_valid}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_data", {16'd0, data_out}, 32'd0);
    checkOutput("rst_addr", {16'd0, resp_addr}, 32'd0);
    checkOutput("rst_valid1", {31'd0, valid1}, 32'd0);
    checkOutput("rst_busy1", {31'd0, busy1}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    mon_on = 1'b1;

    $display("[TB] table-driven request stream");
    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].en, vecs[i].wr, vecs[i].addr, vecs[i].din,
                    vecs[i].exp_data, vecs[i].exp_addr);
    end
    for (int i = 0; i < LAT + 3; i++) applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);

    $display("[TB] reset with reads in flight");
    applyStimulus(1'b1, 1'b0, 16'h0000, 16'h0, 16'h1111, 16'h0000);
    applyStimulus(1'b1, 1'b0, 16'h0002, 16'h0, 16'h2222, 16'h0002);
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0, 16'h0, 16'h0);
    @(posedge clk);
    @(posedge clk);
    #2;
    checkOutput("pre_rst_valid", {31'd0, data_valid}, 32'd1);
    checkOutput("pre_rst_data", {16'd0, data_out}, 32'h1111);
    checkOutput("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    sb.delete();
    #1;
    checkOutput("mid_rst_valid", {31'd0, data_valid}, 32'd0);
    checkOutput("mid_rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("mid_rst_data", {16'd0, data_out}, 32'd0);
    checkOutput("mid_rst_addr", {16'd0, resp_addr}, 32'd0);
    @(negedge clk);
    enable  = 1'b1;
    wr      = 1'b1;
    addr    = 16'h0010;
    data_in = 16'hDEAD;
    @(posedge clk);
    #2 rst = 1'b0;
    for (int i = 0; i < LAT + 3; i++) applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
    applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0, 16'hBEEF, 16'h0010);
    for (int i = 0; i < LAT + 2; i++) applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);

    $display("[TB] single-cycle latency instance");
    @(negedge clk);
    en1 = 1'b1; wr1 = 1'b1; addr1 = 16'h0100; din1 = 16'h0042;
    @(negedge clk);
    en1 = 1'b1; wr1 = 1'b0; addr1 = 16'h0100;
    @(negedge clk);
    en1 = 1'b1; wr1 = 1'b0; addr1 = 16'h0101;
    checkOutput("l1_valid", {31'd0, valid1}, 32'd1);
    checkOutput("l1_data", {16'd0, dout1}, 32'h0042);
    checkOutput("l1_addr", {16'd0, raddr1}, 32'h0100);
    checkOutput("l1_busy", {31'd0, busy1}, 32'd1);
    @(negedge clk);
    en1 = 1'b0;
    checkOutput("l1_valid_b2b", {31'd0, valid1}, 32'd1);
    checkOutput("l1_data_b2b", {16'd0, dout1}, 32'h0042);
    checkOutput("l1_addr_b2b", {16'd0, raddr1}, 32'h0100);
    @(negedge clk);
    checkOutput("l1_idle_valid", {31'd0, valid1}, 32'd0);
    checkOutput("l1_idle_busy", {31'd0, busy1}, 32'd0);
    checkOutput("l1_idle_data", {16'd0, dout1}, 32'd0);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    checkOutput("drain_empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
